jump_ctrl: RTL and testbench
============================

Name: jump_ctrl

Overview:
- Sequences jump-class instructions (j, jal, jr) in the 5-stage MIPS pipeline. Sits beside the ID stage.
- Drives PC redirect and IF/ID flush.
- Stalls jr until its rs operand is safe to read.
- Drives the link-register select: destination forced to r31, link value PC+1.
- Keeps a saturating count of taken redirects for debug.

Parameters:
- PC_W, 5, width of PC and jump target (32-word instruction memory).
- DATA_W, 32, register data width.
- CNT_W, 8, width of redirect counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  ID-stage instruction is valid
- id_jump  in  1  decoded j
- id_jal  in  1  decoded jal
- id_jr  in  1  decoded jr
- id_rs  in  5  rs field of ID instruction
- id_target  in  PC_W  immediate jump target (j/jal)
- id_pc_plus1  in  PC_W  PC+1 of ID instruction
- rs_data  in  DATA_W  register-file read of rs
- ex_regwrite, ex_memread  in  1 each  EX-stage write/load flags
- ex_rd  in  5  EX-stage destination
- mem_regwrite, mem_memread  in  1 each  MEM-stage write/load flags
- mem_rd  in  5  MEM-stage destination
- stall  out  1  freeze PC and IF/ID (combinational)
- pc_load  out  1  load pc_target into PC (registered)
- pc_target  out  PC_W  redirect address (registered)
- flush_if  out  1  squash IF/ID contents (registered)
- link_sel  out  1  select r31 as write register for the EX-bound instruction (registered)
- link_pc  out  PC_W  link value written to r31 (registered)
- redirect_cnt  out  CNT_W  saturating count of redirects

Behaviour:
- Reset (async, any state): state=IDLE, and the following are all 0: stall, pc_load, pc_target, flush_if, link_sel, link_pc, redirect_cnt.
- Decode priority when several flags are set: jr > jal > jump. Flags are qualified by id_valid.
- States: IDLE, JR_WAIT, REDIRECT.
- jr hazard (combinational), rs_haz true when id_rs != 0 and either:
  - ex_regwrite & ex_rd == id_rs, or
  - mem_regwrite & mem_memread & mem_rd == id_rs.
  - A MEM non-load writer is not a hazard: it is forwarded into rs_data by the existing forward path.
- IDLE:
  - jump/jal at cycle N: capture target = id_target. Go to REDIRECT at N+1.
  - jal additionally captures link_pc = id_pc_plus1.
  - jr with rs_haz: stall=1 in the same cycle. Go to JR_WAIT.
  - jr without rs_haz: capture target = rs_data[PC_W-1:0]. Go to REDIRECT.
- JR_WAIT:
  - stall=1 while rs_haz. ID inputs are held by the stall.
  - When rs_haz clears: stall=0, capture rs_data, go to REDIRECT.
  - Maximum occupancy: 2 cycles (EX load, then MEM load).
- REDIRECT (exactly 1 cycle):
  - pc_load=1, pc_target=captured value, flush_if=1.
  - link_sel=1 only for jal.
  - redirect_cnt increments, saturating at all-ones.
  - ID inputs are ignored: that instruction is the wrong-path fetch being flushed.
  - Next state: IDLE.
- Outputs hold values only in REDIRECT: pc_load, flush_if, link_sel are 1-cycle pulses. link_pc holds its last captured value.
- Latency: jump/jal decoded at N produces redirect at N+1. jr with no hazard likewise. jr with k hazard cycles produces redirect at N+k+1.
- Fixed behaviour:
  - id_rs = 0 never stalls.
  - Truncation: the upper DATA_W-PC_W bits of rs_data are discarded; no alignment check.
  - Reset asserted mid-JR_WAIT or mid-REDIRECT aborts: no pc_load pulse after reset release.
  - A second jump immediately after a redirect is seen only in the cycle following REDIRECT.

Test Plan:
- j, id_target=5'd20 at cycle N: next cycle pc_load=1, pc_target=20, flush_if=1, link_sel=0, redirect_cnt 0->1. All pulses drop at N+2.
- jal, id_target=9, id_pc_plus1=4: next cycle pc_target=9, link_sel=1, link_pc=4. link_sel low the following cycle.
- jr rs=8, ex_memread & ex_regwrite & ex_rd=8:
  - stall high at N.
  - At N+1, mem_memread & mem_rd=8: stall still high.
  - At N+2, hazard clear, rs_data=32'h0000_0013: pc_target=19 at N+3.
- jr rs=0 with ex_regwrite & ex_rd=0: no stall, redirect next cycle. jr rs=5 with MEM non-load writer rd=5: no stall.
- jr, jal and j asserted together: jr path taken, link_sel=0. Then 256 consecutive jumps: redirect_cnt saturates at 255.
- Reset pulsed while in JR_WAIT: stall, pc_load and redirect_cnt drop to 0 immediately. State returns to IDLE, with no pulse after reset release.

Source files
------------

// File: rtl/jump_ctrl.sv
// Purpose : sequences j/jal/jr beside ID; drives PC redirect, IF/ID flush, r31 link select.
// Latency : j/jal/jr-no-hazard decoded at N redirect at N+1; jr with k hazard cycles at N+k+1.
// Backpr. : stall (combinational) freezes PC and IF/ID while a jr waits on its rs producer.
//
// Ports:
//   clk, reset                      rising-edge clock, async active-high reset
//   id_valid, id_jump/jal/jr        ID-stage decode flags (qualified by id_valid)
//   id_rs, id_target, id_pc_plus1   ID-stage rs field, immediate target, PC+1
//   rs_data                         register-file (forwarded) read of rs
//   ex_*/mem_* regwrite/memread/rd  downstream writers used for the jr hazard check
//   stall                           combinational freeze of PC and IF/ID
//   pc_load, pc_target, flush_if    registered redirect pulse, address and squash
//   link_sel, link_pc               registered r31 select pulse and held link value
//   redirect_cnt                    saturating count of redirects
module jump_ctrl #(
  parameter int PC_W   = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic              id_jump,
  input  logic              id_jal,
  input  logic              id_jr,
  input  logic [4:0]        id_rs,
  input  logic [PC_W-1:0]   id_target,
  input  logic [PC_W-1:0]   id_pc_plus1,
  input  logic [DATA_W-1:0] rs_data,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [4:0]        ex_rd,
  input  logic              mem_regwrite,
  input  logic              mem_memread,
  input  logic [4:0]        mem_rd,
  output logic              stall,
  output logic              pc_load,
  output logic [PC_W-1:0]   pc_target,
  output logic              flush_if,
  output logic              link_sel,
  output logic [PC_W-1:0]   link_pc,
  output logic [CNT_W-1:0]  redirect_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    JR_WAIT  = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  // What gets latched on the edge that enters REDIRECT.
  typedef struct packed {
    logic [PC_W-1:0] target;
    logic            is_jal;
  } redir_t;

  state_t state, next_state;

  logic   dec_jr, dec_jal, dec_j;
  logic   rs_haz;
  logic   capture_en;
  logic   link_cap;
  logic   stall_raw;
  redir_t cap;

  logic [PC_W-1:0] rs_target;

  // Upper rs_data bits are truncated away; ex_memread does not matter because
  // any EX writer of rs is a hazard whether or not it is a load.
  logic unused_bits;
  assign unused_bits = ^{rs_data[DATA_W-1:PC_W], ex_memread};

  assign rs_target = rs_data[PC_W-1:0];

  // Priority jr > jal > j, all qualified by id_valid.
  assign dec_jr  = id_valid & id_jr;
  assign dec_jal = id_valid & id_jal & ~id_jr;
  assign dec_j   = id_valid & id_jump & ~id_jr & ~id_jal;

  // A MEM-stage non-load result reaches rs_data through the forward path, so
  // only an EX writer or a MEM load can leave rs unreadable this cycle.
  assign rs_haz = (id_rs != 5'd0) &&
                  ((ex_regwrite && (ex_rd == id_rs)) ||
                   (mem_regwrite && mem_memread && (mem_rd == id_rs)));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (dec_jr) begin
          next_state = rs_haz ? JR_WAIT : REDIRECT;
        end else if (dec_jal || dec_j) begin
          next_state = REDIRECT;
        end
      end
      JR_WAIT: begin
        if (!rs_haz) begin
          next_state = REDIRECT;
        end
      end
      REDIRECT: begin
        // The ID instruction here is the wrong-path fetch being flushed.
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Output / capture-control logic.
  always_comb begin
    stall_raw  = 1'b0;
    capture_en = 1'b0;
    link_cap   = 1'b0;
    cap.target = id_target;
    cap.is_jal = 1'b0;
    case (state)
      IDLE: begin
        if (dec_jr) begin
          if (rs_haz) begin
            stall_raw = 1'b1;
          end else begin
            capture_en = 1'b1;
            cap.target = rs_target;
          end
        end else if (dec_jal) begin
          capture_en = 1'b1;
          link_cap   = 1'b1;
          cap.is_jal = 1'b1;
        end else if (dec_j) begin
          capture_en = 1'b1;
        end
      end
      JR_WAIT: begin
        // ID inputs are frozen by our own stall, so id_rs is still the jr's rs.
        if (rs_haz) begin
          stall_raw = 1'b1;
        end else begin
          capture_en = 1'b1;
          cap.target = rs_target;
        end
      end
      default: begin
      end
    endcase
  end

  // Stall is combinational from ID/EX/MEM; force it low during reset so the
  // pipeline is released the instant reset is applied.
  assign stall = stall_raw & ~reset;

  // Registered outputs. capture_en is exactly "entering REDIRECT", so the
  // pulses below are high for precisely the REDIRECT cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_load      <= 1'b0;
      flush_if     <= 1'b0;
      link_sel     <= 1'b0;
      pc_target    <= '0;
      link_pc      <= '0;
      redirect_cnt <= '0;
    end else begin
      pc_load  <= capture_en;
      flush_if <= capture_en;
      link_sel <= capture_en & cap.is_jal;
      if (capture_en) begin
        pc_target <= cap.target;
      end
      if (link_cap) begin
        link_pc <= id_pc_plus1;
      end
      if (capture_en && (redirect_cnt != {CNT_W{1'b1}})) begin
        redirect_cnt <= redirect_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jump_ctrl.sv
// Purpose : self-checking bench for jump_ctrl, directed scenarios plus random vs a reference model.
// Latency : checks redirect one cycle after decode and after each hazard cycle.
// Backpr. : ID inputs are held by the bench whenever stall is expected.
module tb_jump_ctrl;

  localparam int PC_W   = 5;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

  logic              clk;
  logic              reset;
  logic              id_valid, id_jump, id_jal, id_jr;
  logic [4:0]        id_rs;
  logic [PC_W-1:0]   id_target, id_pc_plus1;
  logic [DATA_W-1:0] rs_data;
  logic              ex_regwrite, ex_memread;
  logic [4:0]        ex_rd;
  logic              mem_regwrite, mem_memread;
  logic [4:0]        mem_rd;
  logic              stall, pc_load, flush_if, link_sel;
  logic [PC_W-1:0]   pc_target, link_pc;
  logic [CNT_W-1:0]  redirect_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  jump_ctrl #(.PC_W(PC_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_jump(id_jump), .id_jal(id_jal), .id_jr(id_jr),
    .id_rs(id_rs), .id_target(id_target), .id_pc_plus1(id_pc_plus1),
    .rs_data(rs_data),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_rd(mem_rd),
    .stall(stall), .pc_load(pc_load), .pc_target(pc_target), .flush_if(flush_if),
    .link_sel(link_sel), .link_pc(link_pc), .redirect_cnt(redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_jump = 0; id_jal = 0; id_jr = 0;
    id_rs = 0; id_target = 0; id_pc_plus1 = 0; rs_data = 0;
    ex_regwrite = 0; ex_memread = 0; ex_rd = 0;
    mem_regwrite = 0; mem_memread = 0; mem_rd = 0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    reset = 1;
    cyc();
    cyc();
    reset = 0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    #3;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %0b want 0", stall); end
    n_cmp++; if (pc_load !== 1'b0) begin n_fail++; $display("FAIL rst_pc_load: got %0b want 0", pc_load); end
    n_cmp++; if (pc_target !== 5'd0) begin n_fail++; $display("FAIL rst_pc_target: got %0d want 0", pc_target); end
    n_cmp++; if (flush_if !== 1'b0) begin n_fail++; $display("FAIL rst_flush_if: got %0b want 0", flush_if); end
    n_cmp++; if (link_sel !== 1'b0) begin n_fail++; $display("FAIL rst_link_sel: got %0b want 0", link_sel); end
    n_cmp++; if (link_pc !== 5'd0) begin n_fail++; $display("FAIL rst_link_pc: got %0d want 0", link_pc); end
    n_cmp++; if (redirect_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", redirect_cnt); end
    cyc();
    reset = 0;
    #1;
  endtask

  task automatic test_jump();
    reset_dut();
    id_valid = 1; id_jump = 1; id_target = 5'd20;
    #2;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL j_stall: got %0b want 0", stall); end
    cyc();
    n_cmp++; if (pc_load !== 1'b1) begin n_fail++; $display("FAIL j_pc_load: got %0b want 1", pc_load); end
    n_cmp++; if (pc_target !== 5'd20) begin n_fail++; $display("FAIL j_pc_target: got %0d want 20", pc_target); end
    n_cmp++; if (flush_if !== 1'b1) begin n_fail++; $display("FAIL j_flush_if: got %0b want 1", flush_if); end
    n_cmp++; if (link_sel !== 1'b0) begin n_fail++; $display("FAIL j_link_sel: got %0b want 0", link_sel); end
    n_cmp++; if (redirect_cnt !== 8'd1) begin n_fail++; $display("FAIL j_cnt: got %0d want 1", redirect_cnt); end
    clear_inputs();
    cyc();
    n_cmp++; if (pc_load !== 1'b0) begin n_fail++; $display("FAIL j_pc_load_drop: got %0b want 0", pc_load); end
    n_cmp++; if (flush_if !== 1'b0) begin n_fail++; $display("FAIL j_flush_drop: got %0b want 0", flush_if); end
    n_cmp++; if (redirect_cnt !== 8'd1) begin n_fail++; $display("FAIL j_cnt_hold: got %0d want 1", redirect_cnt); end
  endtask

  task automatic test_jal();
    reset_dut();
    id_valid = 1; id_jal = 1; id_target = 5'd9; id_pc_plus1 = 5'd4;
    cyc();
    n_cmp++; if (pc_load !== 1'b1) begin n_fail++; $display("FAIL jal_pc_load: got %0b want 1", pc_load); end
    n_cmp++; if (pc_target !== 5'd9) begin n_fail++; $display("FAIL jal_pc_target: got %0d want 9", pc_target); end
    n_cmp++; if (link_sel !== 1'b1) begin n_fail++; $display("FAIL jal_link_sel: got %0b want 1", link_sel); end
    n_cmp++; if (link_pc !== 5'd4) begin n_fail++; $display("FAIL jal_link_pc: got %0d want 4", link_pc); end
    clear_inputs();
    cyc();
    n_cmp++; if (link_sel !== 1'b0) begin n_fail++; $display("FAIL jal_link_drop: got %0b want 0", link_sel); end
    n_cmp++; if (link_pc !== 5'd4) begin n_fail++; $display("FAIL jal_link_pc_hold: got %0d want 4", link_pc); end
  endtask

  task automatic test_jr_hazard();
    reset_dut();
    id_valid = 1; id_jr = 1; id_rs = 5'd8; rs_data = 32'hDEAD_BEEF;
    ex_regwrite = 1; ex_memread = 1; ex_rd = 5'd8;
    #2;
    n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL jrh_stall_n: got %0b want 1", stall); end
    cyc();
    n_cmp++; if (pc_load !== 1'b0) begin n_fail++; $display("FAIL jrh_pc_load_n1: got %0b want 0", pc_load); end
    ex_regwrite = 0; ex_memread = 0; ex_rd = 0;
    mem_regwrite = 1; mem_memread = 1; mem_rd = 5'd8;
    #2;
    n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL jrh_stall_n1: got %0b want 1", stall); end
    cyc();
    n_cmp++; if (pc_load !== 1'b0) begin n_fail++; $display("FAIL jrh_pc_load_n2: got %0b want 0", pc_load); end
    mem_regwrite = 0; mem_memread = 0; mem_rd = 0;
    rs_data = 32'h0000_0013;
    #2;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL jrh_stall_n2: got %0b want 0", stall); end
    cyc();
    n_cmp++; if (pc_load !== 1'b1) begin n_fail++; $display("FAIL jrh_pc_load_n3: got %0b want 1", pc_load); end
    n_cmp++; if (pc_target !== 5'd19) begin n_fail++; $display("FAIL jrh_pc_target: got %0d want 19", pc_target); end
    n_cmp++; if (link_sel !== 1'b0) begin n_fail++; $display("FAIL jrh_link_sel: got %0b want 0", link_sel); end
    clear_inputs();
    cyc();
  endtask

  task automatic test_jr_no_stall();
    reset_dut();
    id_valid = 1; id_jr = 1; id_rs = 5'd0; rs_data = 32'd7;
    ex_regwrite = 1; ex_rd = 5'd0;
    #2;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL jr0_stall: got %0b want 0", stall); end
    cyc();
    n_cmp++; if (pc_load !== 1'b1) begin n_fail++; $display("FAIL jr0_pc_load: got %0b want 1", pc_load); end
    n_cmp++; if (pc_target !== 5'd7) begin n_fail++; $display("FAIL jr0_pc_target: got %0d want 7", pc_target); end
    clear_inputs();
    cyc();
    // MEM non-load writer is forwarded; upper rs_data bits are discarded.
    id_valid = 1; id_jr = 1; id_rs = 5'd5; rs_data = 32'hFFFF_FFEB;
    mem_regwrite = 1; mem_memread = 0; mem_rd = 5'd5;
    #2;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL jrfwd_stall: got %0b want 0", stall); end
    cyc();
    n_cmp++; if (pc_load !== 1'b1) begin n_fail++; $display("FAIL jrfwd_pc_load: got %0b want 1", pc_load); end
    n_cmp++; if (pc_target !== 5'd11) begin n_fail++; $display("FAIL jrfwd_pc_target: got %0d want 11", pc_target); end
    clear_inputs();
    cyc();
  endtask

  task automatic test_priority();
    reset_dut();
    // Flags without id_valid do nothing.
    id_valid = 0; id_jump = 1; id_jal = 1; id_jr = 1; id_target = 5'd9;
    cyc();
    n_cmp++; if (pc_load !== 1'b0) begin n_fail++; $display("FAIL prio_invalid: got %0b want 0", pc_load); end
    id_valid = 1; id_rs = 5'd3; rs_data = 32'd22; id_pc_plus1 = 5'd4;
    cyc();
    n_cmp++; if (pc_target !== 5'd22) begin n_fail++; $display("FAIL prio_pc_target: got %0d want 22", pc_target); end
    n_cmp++; if (link_sel !== 1'b0) begin n_fail++; $display("FAIL prio_link_sel: got %0b want 0", link_sel); end
    n_cmp++; if (link_pc !== 5'd0) begin n_fail++; $display("FAIL prio_link_pc: got %0d want 0", link_pc); end
    clear_inputs();
    cyc();
  endtask

  task automatic test_saturation();
    reset_dut();
    id_valid = 1; id_jump = 1;
    for (int r = 1; r <= 256; r++) begin
      id_target = 5'(r);
      cyc();
      n_cmp++;
      if (pc_load !== 1'b1 || redirect_cnt !== 8'((r > 255) ? 255 : r)) begin
        n_fail++;
        $display("FAIL sat_redirect_%0d: got load=%0b cnt=%0d want load=1 cnt=%0d",
                 r, pc_load, redirect_cnt, (r > 255) ? 255 : r);
      end
      cyc();
      n_cmp++; if (pc_load !== 1'b0) begin n_fail++; $display("FAIL sat_gap_%0d: got %0b want 0", r, pc_load); end
    end
    clear_inputs();
  endtask

  task automatic test_reset_abort();
    reset_dut();
    id_valid = 1; id_jump = 1; id_target = 5'd3;
    cyc();
    clear_inputs();
    cyc();
    // Enter JR_WAIT and reset while waiting.
    id_valid = 1; id_jr = 1; id_rs = 5'd8; ex_regwrite = 1; ex_memread = 1; ex_rd = 5'd8;
    cyc();
    #2;
    n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rwait_pre_stall: got %0b want 1", stall); end
    reset = 1;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rwait_stall: got %0b want 0", stall); end
    n_cmp++; if (redirect_cnt !== 8'd0) begin n_fail++; $display("FAIL rwait_cnt: got %0d want 0", redirect_cnt); end
    clear_inputs();
    cyc();
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++; if (pc_load !== 1'b0) begin n_fail++; $display("FAIL rwait_no_pulse_%0d: got %0b want 0", i, pc_load); end
    end
    // Reset during REDIRECT.
    id_valid = 1; id_jump = 1; id_target = 5'd12;
    cyc();
    clear_inputs();
    reset = 1;
    #1;
    n_cmp++; if (pc_load !== 1'b0) begin n_fail++; $display("FAIL rredir_pc_load: got %0b want 0", pc_load); end
    cyc();
    reset = 0;
    cyc();
    n_cmp++; if (pc_load !== 1'b0) begin n_fail++; $display("FAIL rredir_no_pulse: got %0b want 0", pc_load); end
  endtask

  // Random traffic checked against a cycle model written from the rules:
  // "a redirect slot follows each accepted jump; a jr waits while rs is unsafe".
  task automatic test_random();
    bit       in_slot = 0;     // the current cycle is a redirect cycle
    bit       jr_pending = 0;  // a jr is waiting on its rs
    bit       held = 0;        // previous cycle stalled, so ID inputs are frozen
    bit       nxt_slot, nxt_link, haz, e_stall, jr_sel, jal_sel, j_sel;
    int       e_cnt = 0;
    bit [4:0] e_target = 0;
    bit [4:0] e_link_pc = 0;
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      if (!held) begin
        id_valid    = ($urandom_range(0, 3) != 0);
        id_jump     = $urandom_range(0, 1);
        id_jal      = $urandom_range(0, 1);
        id_jr       = $urandom_range(0, 1);
        id_rs       = 5'($urandom_range(0, 7));
        id_target   = 5'($urandom);
        id_pc_plus1 = 5'($urandom);
      end
      rs_data      = $urandom;
      ex_regwrite  = ($urandom_range(0, 2) == 0);
      ex_memread   = $urandom_range(0, 1);
      ex_rd        = ($urandom_range(0, 1) != 0) ? id_rs : 5'($urandom);
      mem_regwrite = ($urandom_range(0, 2) == 0);
      mem_memread  = $urandom_range(0, 1);
      mem_rd       = ($urandom_range(0, 1) != 0) ? id_rs : 5'($urandom);

      haz = (id_rs != 0) &&
            ((ex_regwrite && ex_rd == id_rs) ||
             (mem_regwrite && mem_memread && mem_rd == id_rs));
      jr_sel  = id_valid && id_jr;
      jal_sel = id_valid && id_jal && !id_jr;
      j_sel   = id_valid && id_jump && !id_jr && !id_jal;
      e_stall = !in_slot && (jr_pending || jr_sel) && haz;
      #2;
      n_cmp++; if (stall !== e_stall) begin n_fail++; $display("FAIL rnd_stall c%0d: got %0b want %0b", c, stall, e_stall); end

      nxt_slot = 0;
      nxt_link = 0;
      if (!in_slot) begin
        if (jr_pending || jr_sel) begin
          if (haz) begin
            jr_pending = 1;
          end else begin
            jr_pending = 0;
            nxt_slot   = 1;
            e_target   = rs_data[4:0];
          end
        end else if (jal_sel || j_sel) begin
          nxt_slot = 1;
          e_target = id_target;
          if (jal_sel) begin
            nxt_link  = 1;
            e_link_pc = id_pc_plus1;
          end
        end
      end
      if (nxt_slot && e_cnt < 255) e_cnt++;
      in_slot = nxt_slot;
      held    = e_stall;

      cyc();
      n_cmp++;
      if (pc_load !== in_slot || flush_if !== in_slot || link_sel !== nxt_link) begin
        n_fail++;
        $display("FAIL rnd_pulses c%0d: got load=%0b flush=%0b link=%0b want %0b/%0b/%0b",
                 c, pc_load, flush_if, link_sel, in_slot, in_slot, nxt_link);
      end
      n_cmp++;
      if (pc_target !== e_target || link_pc !== e_link_pc || redirect_cnt !== 8'(e_cnt)) begin
        n_fail++;
        $display("FAIL rnd_values c%0d: got tgt=%0d lpc=%0d cnt=%0d want %0d/%0d/%0d",
                 c, pc_target, link_pc, redirect_cnt, e_target, e_link_pc, e_cnt);
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset = 0;
    test_reset();
    test_jump();
    test_jal();
    test_jr_hazard();
    test_jr_no_stall();
    test_priority();
    test_saturation();
    test_reset_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
